// File: rtl/lap_timer.sv
// Lap stopwatch with finish-line crossing detection, lap counting and
// best-lap tracking. Time is kept in binary ticks of 1/TICK_HZ seconds.
module lap_timer #(
  parameter int CLK_FREQ_HZ  = 65_000_000,
  parameter int TICK_HZ      = 100,
  parameter int MAX_TIME     = 59999,
  parameter int MIN_LAP_TIME = 300,
  parameter int NUM_LAPS     = 3
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        race_start,
  input  logic        race_abort,
  input  logic        clear_best,
  input  logic        finish_line,
  output logic [15:0] cur_lap_time,
  output logic [15:0] best_lap_time,
  output logic        best_valid,
  output logic [7:0]  lap_count,
  output logic        new_best,
  output logic        race_done
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [15:0]   MAX_T      = 16'(MAX_TIME);
  localparam logic [15:0]   MIN_T      = 16'(MIN_LAP_TIME);
  localparam logic [7:0]    LAPS       = 8'(NUM_LAPS);

  typedef enum logic [1:0] {S_IDLE, S_RUNNING, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [15:0]   r_cur, w_cur_nxt;
  logic [7:0]    r_laps, w_laps_nxt;
  logic [15:0]   r_best, w_best_nxt;
  logic          r_best_valid, w_best_valid_nxt;
  logic          r_new_best;
  logic          r_fl_q;

  logic w_cross, w_tick, w_valid, w_last, w_better, w_commit;

  // Crossing is the rising edge of the finish-line level; a valid lap needs
  // the minimum lap time so bounces and reverse crossings are rejected.
  // Clearing best in the same cycle as a valid lap lets that lap become best.
  assign w_cross  = finish_line & ~r_fl_q;
  assign w_tick   = (r_state == S_RUNNING) && (r_presc == PRESC_LAST);
  assign w_valid  = (r_state == S_RUNNING) && w_cross && !race_abort &&
                    (r_cur >= MIN_T);
  assign w_last   = (r_laps + 8'd1) == LAPS;
  assign w_better = !r_best_valid || clear_best || (r_cur < r_best);
  assign w_commit = w_valid && w_better;

  // State register and finish-line history
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_fl_q  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fl_q  <= finish_line;
    end
  end

  // Next state plus lap timer, prescaler and lap counter updates
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_cur_nxt   = r_cur;
    w_laps_nxt  = r_laps;
    if (race_abort) begin
      w_state_nxt = S_IDLE;
      w_presc_nxt = '0;
      w_cur_nxt   = '0;
      w_laps_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_presc_nxt = '0;
          w_cur_nxt   = '0;
          w_laps_nxt  = '0;
          if (race_start) w_state_nxt = S_RUNNING;
        end
        S_RUNNING: begin
          if (w_valid) begin
            // Final lap keeps its time on display; others restart the clock.
            w_laps_nxt  = r_laps + 8'd1;
            w_presc_nxt = '0;
            w_cur_nxt   = w_last ? r_cur : 16'd0;
            if (w_last) w_state_nxt = S_DONE;
          end else if (w_tick) begin
            w_presc_nxt = '0;
            w_cur_nxt   = (r_cur < MAX_T) ? r_cur + 16'd1 : r_cur;
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
        end
        S_DONE: begin
          if (race_start) begin
            w_state_nxt = S_RUNNING;
            w_presc_nxt = '0;
            w_cur_nxt   = '0;
            w_laps_nxt  = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Best-lap next value: a commit outranks clear_best
  always_comb begin
    w_best_nxt       = r_best;
    w_best_valid_nxt = r_best_valid;
    if (w_commit) begin
      w_best_nxt       = r_cur;
      w_best_valid_nxt = 1'b1;
    end else if (clear_best) begin
      w_best_nxt       = '0;
      w_best_valid_nxt = 1'b0;
    end
  end

  // Timing datapath registers
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_cur   <= '0;
      r_laps  <= '0;
    end else begin
      r_presc <= w_presc_nxt;
      r_cur   <= w_cur_nxt;
      r_laps  <= w_laps_nxt;
    end
  end

  // Best-lap registers; survive race_abort, cleared only by reset/clear_best
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_best       <= '0;
      r_best_valid <= 1'b0;
      r_new_best   <= 1'b0;
    end else begin
      r_best       <= w_best_nxt;
      r_best_valid <= w_best_valid_nxt;
      r_new_best   <= w_commit;
    end
  end

  assign cur_lap_time  = r_cur;
  assign best_lap_time = r_best;
  assign best_valid    = r_best_valid;
  assign lap_count     = r_laps;
  assign new_best      = r_new_best;
  assign race_done     = (r_state == S_DONE);

endmodule
